sc_lsu: RTL and testbench

Load/store unit for the single-cycle RV32I core: sits between execute (ALU address, rs2 data) and the data memory port. Converts LOAD/STORE instructions into word-aligned data-memory requests with byte enables, stalls the core while the access is outstanding, and returns sign- or zero-extended load data for writeback. Misaligned, illegal-funct3 and out-of-range accesses are trapped and never reach memory.

---
 rtl/sc_core_pkg.sv | 40 ++++
 rtl/sc_lsu_align.sv | 55 +++++
 rtl/sc_lsu.sv | 147 ++++++++++++++
 tb/tb_sc_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_core_pkg.sv
// Shared types and constants for the single-cycle core: opcodes, LSU state,
// memory access widths and LSU exception causes.
package sc_core_pkg;

    // Data memory window in byte addresses
    localparam int unsigned D_MEM_OFFSET = 61440;
    localparam int unsigned D_MEM_SIZE   = 65536;

    typedef logic [6:0] t_opcode;

    localparam t_opcode OPC_LOAD  = 7'b0000011;
    localparam t_opcode OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DONE,
        LSU_EXC
    } t_lsu_state;

    typedef enum logic [2:0] {
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } t_mem_width;

    typedef enum logic [1:0] {
        EXC_ILLEGAL        = 2'b00,
        EXC_LOAD_MISALIGN  = 2'b01,
        EXC_STORE_MISALIGN = 2'b10,
        EXC_ACCESS_FAULT   = 2'b11
    } t_lsu_exc;

endpackage

// File: rtl/sc_lsu_align.sv
// Combinational lane logic: store data replication / byte enables and
// load byte/halfword extraction with sign or zero extension.
module sc_lsu_align
    import sc_core_pkg::*;
(
    input  t_mem_width  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        byte_sel = rd_data[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = rd_data[7:0];
            2'd1: byte_sel = rd_data[15:8];
            2'd2: byte_sel = rd_data[23:16];
            2'd3: byte_sel = rd_data[31:24];
            default: byte_sel = rd_data[7:0];
        endcase
        half_sel = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    end

    // Lane enables, write data replication and load extension per width
    always_comb begin
        byte_en = 4'b0000;
        wr_data = 32'h0;
        ld_data = 32'h0;
        case (width)
            MEM_LB, MEM_LBU, MEM_SB: byte_en = 4'b0001 << addr_lo;
            MEM_LH, MEM_LHU, MEM_SH: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:                 byte_en = 4'b1111;
        endcase
        case (width)
            MEM_SB:  wr_data = {4{store_data[7:0]}};
            MEM_SH:  wr_data = {2{store_data[15:0]}};
            default: wr_data = store_data;
        endcase
        case (width)
            MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ld_data = {24'h0, byte_sel};
            MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ld_data = {16'h0, half_sel};
            default: ld_data = rd_data;
        endcase
    end

endmodule

// File: rtl/sc_lsu.sv
// Load/store unit: decodes and checks LOAD/STORE, issues one word-aligned
// data memory request, stalls the core until done, returns extended load data.
module sc_lsu
    import sc_core_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LsuValid,
    input  logic [6:0]  LsuOpcode,
    input  logic [2:0]  LsuFunct3,
    input  logic [31:0] LsuAddr,
    input  logic [31:0] LsuStoreData,
    input  logic [4:0]  LsuRd,
    output logic        LsuStall,
    output logic        DMemReq,
    output logic        DMemWr,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemByteEn,
    output logic [31:0] DMemWrData,
    input  logic        DMemGnt,
    input  logic        DMemRspValid,
    input  logic [31:0] DMemRdData,
    output logic        WbValid,
    output logic [4:0]  WbRd,
    output logic [31:0] WbData,
    output logic        LsuExcValid,
    output logic [1:0]  LsuExcCause
);

    t_lsu_state  state_q, state_d;
    t_mem_width  width_q, dec_width, align_width;
    logic [1:0]  addr_lo_q, align_addr_lo;
    logic [4:0]  rd_q;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q, wb_data_q;
    logic [3:0]  be_q;
    logic [1:0]  cause_q;
    logic        is_mem, is_store, illegal, misalign, out_of_range, fault;
    logic [1:0]  fault_cause;
    logic [32:0] addr_ext;
    logic [3:0]  al_byte_en;
    logic [31:0] al_wr_data, al_ld_data;

    assign is_mem   = LsuValid && (LsuOpcode == OPC_LOAD || LsuOpcode == OPC_STORE);
    assign is_store = (LsuOpcode == OPC_STORE);
    assign addr_ext = {1'b0, LsuAddr};

    // Decode width and classify faults: illegal > misaligned > out of range
    always_comb begin
        dec_width = MEM_LW;
        illegal   = 1'b0;
        case (LsuFunct3)
            3'b000:  dec_width = is_store ? MEM_SB : MEM_LB;
            3'b001:  dec_width = is_store ? MEM_SH : MEM_LH;
            3'b010:  dec_width = is_store ? MEM_SW : MEM_LW;
            3'b100:  begin dec_width = MEM_LBU; illegal = is_store; end
            3'b101:  begin dec_width = MEM_LHU; illegal = is_store; end
            default: illegal = 1'b1;
        endcase
        case (dec_width)
            MEM_LH, MEM_LHU, MEM_SH: misalign = LsuAddr[0];
            MEM_LW, MEM_SW:          misalign = (LsuAddr[1:0] != 2'b00);
            default:                 misalign = 1'b0;
        endcase
        out_of_range = (addr_ext < 33'(D_MEM_OFFSET))
                    || (addr_ext >= 33'(D_MEM_OFFSET) + 33'(D_MEM_SIZE));
        fault       = illegal || misalign || out_of_range;
        fault_cause = EXC_ACCESS_FAULT;
        if (illegal)       fault_cause = EXC_ILLEGAL;
        else if (misalign) fault_cause = is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
    end

    // In IDLE the aligner formats the incoming store; afterwards it extracts the load
    assign align_width   = (state_q == LSU_IDLE) ? dec_width : width_q;
    assign align_addr_lo = (state_q == LSU_IDLE) ? LsuAddr[1:0] : addr_lo_q;

    sc_lsu_align u_align (
        .width      (align_width),
        .addr_lo    (align_addr_lo),
        .store_data (LsuStoreData),
        .rd_data    (DMemRdData),
        .byte_en    (al_byte_en),
        .wr_data    (al_wr_data),
        .ld_data    (al_ld_data)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:     if (is_mem) state_d = fault ? LSU_EXC : LSU_REQ;
            LSU_REQ:      if (DMemGnt) state_d = wr_q ? LSU_DONE : LSU_WAIT_RSP;
            LSU_WAIT_RSP: if (DMemRspValid) state_d = LSU_DONE;
            LSU_DONE:     state_d = LSU_IDLE;
            LSU_EXC:      state_d = LSU_IDLE;
            default:      state_d = LSU_IDLE;
        endcase
    end

    // State and latched request/response fields
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= LSU_IDLE;
            width_q   <= MEM_LB;
            addr_lo_q <= 2'b00;
            rd_q      <= 5'd0;
            wr_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            wb_data_q <= 32'h0;
            cause_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == LSU_IDLE && is_mem) begin
                if (fault) begin
                    cause_q <= fault_cause;
                end else begin
                    width_q   <= dec_width;
                    addr_lo_q <= LsuAddr[1:0];
                    rd_q      <= LsuRd;
                    wr_q      <= is_store;
                    addr_q    <= {LsuAddr[31:2], 2'b00};
                    be_q      <= al_byte_en;
                    wdata_q   <= is_store ? al_wr_data : 32'h0;
                end
            end
            if (state_q == LSU_WAIT_RSP && DMemRspValid) begin
                wb_data_q <= al_ld_data;
            end
        end
    end

    assign LsuStall    = (state_q == LSU_IDLE && is_mem)
                      || state_q == LSU_REQ || state_q == LSU_WAIT_RSP;
    assign DMemReq     = (state_q == LSU_REQ);
    assign DMemWr      = wr_q;
    assign DMemAddr    = addr_q;
    assign DMemByteEn  = be_q;
    assign DMemWrData  = wdata_q;
    assign WbValid     = (state_q == LSU_DONE) && !wr_q;
    assign WbRd        = rd_q;
    assign WbData      = wb_data_q;
    assign LsuExcValid = (state_q == LSU_EXC);
    assign LsuExcCause = cause_q;

endmodule

// File: tb/tb_sc_lsu.sv
// Directed bench for sc_lsu with hand-computed expectations.
module tb_sc_lsu;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        LsuValid = 1'b0;
    logic [6:0]  LsuOpcode = 7'd0;
    logic [2:0]  LsuFunct3 = 3'd0;
    logic [31:0] LsuAddr = 32'h0;
    logic [31:0] LsuStoreData = 32'h0;
    logic [4:0]  LsuRd = 5'd0;
    logic        LsuStall;
    logic        DMemReq;
    logic        DMemWr;
    logic [31:0] DMemAddr;
    logic [3:0]  DMemByteEn;
    logic [31:0] DMemWrData;
    logic        DMemGnt = 1'b0;
    logic        DMemRspValid = 1'b0;
    logic [31:0] DMemRdData = 32'h0;
    logic        WbValid;
    logic [4:0]  WbRd;
    logic [31:0] WbData;
    logic        LsuExcValid;
    logic [1:0]  LsuExcCause;

    int errors = 0;
    int checks = 0;

    sc_lsu dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .LsuValid     (LsuValid),
        .LsuOpcode    (LsuOpcode),
        .LsuFunct3    (LsuFunct3),
        .LsuAddr      (LsuAddr),
        .LsuStoreData (LsuStoreData),
        .LsuRd        (LsuRd),
        .LsuStall     (LsuStall),
        .DMemReq      (DMemReq),
        .DMemWr       (DMemWr),
        .DMemAddr     (DMemAddr),
        .DMemByteEn   (DMemByteEn),
        .DMemWrData   (DMemWrData),
        .DMemGnt      (DMemGnt),
        .DMemRspValid (DMemRspValid),
        .DMemRdData   (DMemRdData),
        .WbValid      (WbValid),
        .WbRd         (WbRd),
        .WbData       (WbData),
        .LsuExcValid  (LsuExcValid),
        .LsuExcCause  (LsuExcCause)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 2 time units after the rising edge
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd);
        LsuValid = 1'b1; LsuOpcode = op; LsuFunct3 = f3;
        LsuAddr = addr; LsuStoreData = sdata; LsuRd = rd;
    endtask

    // Load with grant in cycle 1 and response in cycle 2
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] rdata,
                           input logic [31:0] exp);
        drive(OP_LD, f3, addr, 32'h0, 5'd7);
        #1 check_eq({tag, " stall c0"}, 32'(LsuStall), 32'd1);
        cyc();
        check_eq({tag, " req c1"}, 32'(DMemReq), 32'd1);
        check_eq({tag, " wr c1"}, 32'(DMemWr), 32'd0);
        check_eq({tag, " addr c1"}, DMemAddr, {addr[31:2], 2'b00});
        check_eq({tag, " be c1"}, 32'(DMemByteEn), 32'(be));
        DMemGnt = 1'b1;
        cyc();
        DMemGnt = 1'b0;
        check_eq({tag, " req c2"}, 32'(DMemReq), 32'd0);
        check_eq({tag, " stall c2"}, 32'(LsuStall), 32'd1);
        DMemRspValid = 1'b1; DMemRdData = rdata;
        cyc();
        DMemRspValid = 1'b0;
        check_eq({tag, " wbvalid c3"}, 32'(WbValid), 32'd1);
        check_eq({tag, " wbdata"}, WbData, exp);
        check_eq({tag, " wbrd"}, 32'(WbRd), 32'd7);
        check_eq({tag, " stall c3"}, 32'(LsuStall), 32'd0);
        LsuValid = 1'b0;
        cyc();
        check_eq({tag, " wbvalid c4"}, 32'(WbValid), 32'd0);
    endtask

    task automatic do_exc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] cause);
        drive(op, f3, addr, 32'h1234_5678, 5'd3);
        #1 check_eq({tag, " stall c0"}, 32'(LsuStall), 32'd1);
        cyc();
        check_eq({tag, " excvalid"}, 32'(LsuExcValid), 32'd1);
        check_eq({tag, " cause"}, 32'(LsuExcCause), 32'(cause));
        check_eq({tag, " no req"}, 32'(DMemReq), 32'd0);
        check_eq({tag, " stall c1"}, 32'(LsuStall), 32'd0);
        LsuValid = 1'b0;
        cyc();
        check_eq({tag, " exc drop"}, 32'(LsuExcValid), 32'd0);
        check_eq({tag, " no req c2"}, 32'(DMemReq), 32'd0);
    endtask

    initial begin
        cyc();
        cyc();
        Rst = 1'b0;
        cyc();
        check_eq("rst stall", 32'(LsuStall), 32'd0);
        check_eq("rst req", 32'(DMemReq), 32'd0);
        check_eq("rst wbvalid", 32'(WbValid), 32'd0);
        check_eq("rst exc", 32'(LsuExcValid), 32'd0);
        check_eq("rst be", 32'(DMemByteEn), 32'd0);
        check_eq("rst wbdata", WbData, 32'd0);

        // Non-memory opcode is ignored
        drive(7'b0110011, 3'b000, 32'h0000_F000, 32'h0, 5'd1);
        #1 check_eq("alu stall", 32'(LsuStall), 32'd0);
        cyc();
        check_eq("alu req", 32'(DMemReq), 32'd0);
        LsuValid = 1'b0;

        // SB with immediate grant
        drive(OP_ST, 3'b000, 32'h0000_F003, 32'h0000_00A5, 5'd0);
        DMemGnt = 1'b1;
        #1 check_eq("sb stall c0", 32'(LsuStall), 32'd1);
        check_eq("sb req c0", 32'(DMemReq), 32'd0);
        cyc();
        check_eq("sb req c1", 32'(DMemReq), 32'd1);
        check_eq("sb wr", 32'(DMemWr), 32'd1);
        check_eq("sb addr", DMemAddr, 32'h0000_F000);
        check_eq("sb be", 32'(DMemByteEn), 32'b1000);
        check_eq("sb wdata", DMemWrData, 32'hA5A5_A5A5);
        check_eq("sb stall c1", 32'(LsuStall), 32'd1);
        cyc();
        DMemGnt = 1'b0;
        check_eq("sb stall c2", 32'(LsuStall), 32'd0);
        check_eq("sb req c2", 32'(DMemReq), 32'd0);
        check_eq("sb no wb", 32'(WbValid), 32'd0);
        LsuValid = 1'b0;
        cyc();

        // SH upper half
        drive(OP_ST, 3'b001, 32'h0000_F006, 32'h1234_BEEF, 5'd0);
        cyc();
        check_eq("sh be", 32'(DMemByteEn), 32'b1100);
        check_eq("sh wdata", DMemWrData, 32'hBEEF_BEEF);
        check_eq("sh addr", DMemAddr, 32'h0000_F004);
        DMemGnt = 1'b1;
        cyc();
        DMemGnt = 1'b0;
        LsuValid = 1'b0;
        cyc();

        do_load("lb", 3'b000, 32'h0000_F001, 4'b0010, 32'h0000_8000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_F001, 4'b0010, 32'h0000_8000, 32'h0000_0080);
        do_load("lhu", 3'b101, 32'h0000_F002, 4'b1100, 32'hBEEF_0000, 32'h0000_BEEF);
        do_load("lw", 3'b010, 32'h0001_EFFC, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);

        do_exc("lw misalign", OP_LD, 3'b010, 32'h0000_F002, 2'b01);
        do_exc("sh misalign", OP_ST, 3'b001, 32'h0000_F001, 2'b10);
        do_exc("lw range lo", OP_LD, 3'b010, 32'h0000_0100, 2'b11);
        do_exc("lb range hi", OP_LD, 3'b000, 32'h0001_F000, 2'b11);
        do_exc("ld f3 011", OP_LD, 3'b011, 32'h0000_F000, 2'b00);
        do_exc("sb f3 100", OP_ST, 3'b100, 32'h0000_F000, 2'b00);

        // LH with grant withheld 4 cycles and response delayed 3 cycles
        drive(OP_LD, 3'b001, 32'h0000_F002, 32'h0, 5'd9);
        cyc();
        for (int i = 0; i < 4; i++) begin
            check_eq("hold req", 32'(DMemReq), 32'd1);
            check_eq("hold addr", DMemAddr, 32'h0000_F000);
            check_eq("hold be", 32'(DMemByteEn), 32'b1100);
            check_eq("hold stall", 32'(LsuStall), 32'd1);
            cyc();
        end
        DMemGnt = 1'b1;
        check_eq("hold req last", 32'(DMemReq), 32'd1);
        cyc();
        DMemGnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("wait stall", 32'(LsuStall), 32'd1);
            check_eq("wait no wb", 32'(WbValid), 32'd0);
            cyc();
        end
        DMemRspValid = 1'b1; DMemRdData = 32'h8001_0000;
        cyc();
        DMemRspValid = 1'b0;
        check_eq("lh wbvalid", 32'(WbValid), 32'd1);
        check_eq("lh wbdata", WbData, 32'hFFFF_8001);
        check_eq("lh wbrd", 32'(WbRd), 32'd9);
        LsuValid = 1'b0;
        cyc();
        check_eq("lh single wb", 32'(WbValid), 32'd0);

        // Async reset in REQ drops the request without a clock edge
        drive(OP_LD, 3'b010, 32'h0000_F008, 32'h0, 5'd4);
        cyc();
        check_eq("rreq req", 32'(DMemReq), 32'd1);
        LsuValid = 1'b0;
        Rst = 1'b1;
        #1 check_eq("rreq drop", 32'(DMemReq), 32'd0);
        check_eq("rreq stall", 32'(LsuStall), 32'd0);
        Rst = 1'b0;
        cyc();

        // Reset in WAIT_RSP, then a late response
        drive(OP_LD, 3'b010, 32'h0000_F004, 32'h0, 5'd5);
        cyc();
        DMemGnt = 1'b1;
        cyc();
        DMemGnt = 1'b0;
        check_eq("rwait stall", 32'(LsuStall), 32'd1);
        LsuValid = 1'b0;
        Rst = 1'b1;
        #1 Rst = 1'b0;
        check_eq("rwait stall0", 32'(LsuStall), 32'd0);
        DMemRspValid = 1'b1; DMemRdData = 32'h1111_2222;
        cyc();
        DMemRspValid = 1'b0;
        check_eq("late rsp wb", 32'(WbValid), 32'd0);
        check_eq("late rsp req", 32'(DMemReq), 32'd0);
        check_eq("late rsp data", WbData, 32'd0);
        check_eq("late rsp rd", 32'(WbRd), 32'd0);
        check_eq("late rsp addr", DMemAddr, 32'd0);
        cyc();
        check_eq("late rsp wb2", 32'(WbValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
